// File: rtl/riscv_pkg.sv
// ============================================================================
// Module : riscv_pkg
// Shared divide op-codes, issue-unit state encoding and op-class helper.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package riscv_pkg;

    localparam logic [4:0] OP_DIV  = 5'b10100;
    localparam logic [4:0] OP_DIVU = 5'b10101;
    localparam logic [4:0] OP_REM  = 5'b10110;
    localparam logic [4:0] OP_REMU = 5'b10111;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_WAIT  = 3'd2,
        S_OUT   = 3'd3,
        S_DRAIN = 3'd4
    } div_state_t;

    function automatic logic is_div_op(input logic [4:0] op);
        return op[4:2] == 3'b101;
    endfunction

endpackage

`default_nettype wire

// File: rtl/iter_div32.sv
// ============================================================================
// Module : iter_div32
// 32-cycle restoring divider for DIV/DIVU/REM/REMU; done pulses for one cycle.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module iter_div32
    import riscv_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [4:0]  op,
    input  logic [31:0] rs1,
    input  logic [31:0] rs2,
    output logic        done,
    output logic [31:0] result
);

    logic        busy_q;
    logic [5:0]  cnt_q;
    logic [31:0] rem_q;
    logic [31:0] quo_q;
    logic [31:0] dvs_q;
    logic        neg_quo_q;
    logic        neg_rem_q;
    logic        is_rem_q;
    logic        done_q;

    logic        is_signed;
    logic        a_neg;
    logic        b_neg;
    logic [31:0] a_abs;
    logic [31:0] b_abs;
    logic [32:0] shift;
    logic [32:0] diff;

    always_comb begin
        is_signed = (op == OP_DIV) || (op == OP_REM);
        a_neg     = is_signed & rs1[31];
        b_neg     = is_signed & rs2[31];
        a_abs     = a_neg ? -rs1 : rs1;
        b_abs     = b_neg ? -rs2 : rs2;
        shift     = {rem_q, quo_q[31]};
        diff      = shift - {1'b0, dvs_q};
    end

    // Divide-by-zero keeps the all-ones quotient unsigned-looking: no negation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q    <= 1'b0;
            cnt_q     <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            dvs_q     <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            is_rem_q  <= 1'b0;
            done_q    <= 1'b0;
        end else if (start) begin
            busy_q    <= 1'b1;
            cnt_q     <= 6'd32;
            rem_q     <= '0;
            quo_q     <= a_abs;
            dvs_q     <= b_abs;
            neg_quo_q <= (a_neg ^ b_neg) && (rs2 != '0);
            neg_rem_q <= a_neg;
            is_rem_q  <= (op == OP_REM) || (op == OP_REMU);
            done_q    <= 1'b0;
        end else if (busy_q) begin
            if (!diff[32]) begin
                rem_q <= diff[31:0];
                quo_q <= {quo_q[30:0], 1'b1};
            end else begin
                rem_q <= shift[31:0];
                quo_q <= {quo_q[30:0], 1'b0};
            end
            cnt_q <= cnt_q - 6'd1;
            if (cnt_q == 6'd1) begin
                busy_q <= 1'b0;
                done_q <= 1'b1;
            end
        end else begin
            done_q <= 1'b0;
        end
    end

    assign done   = done_q;
    assign result = is_rem_q ? (neg_rem_q ? -rem_q : rem_q)
                             : (neg_quo_q ? -quo_q : quo_q);

endmodule

`default_nettype wire

// File: rtl/div_issue_unit.sv
// ============================================================================
// Module : div_issue_unit
// Queues divide ops, runs them one at a time on iter_div32, offers results to CDB.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module div_issue_unit
    import riscv_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int TAG_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [4:0]       in_op,
    input  logic [31:0]      in_rs1,
    input  logic [31:0]      in_rs2,
    input  logic [TAG_W-1:0] in_tag,
    input  logic             flush,
    output logic             cdb_valid,
    input  logic             cdb_ready,
    output logic [TAG_W-1:0] cdb_tag,
    output logic [31:0]      cdb_data,
    output logic             busy
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [4:0]       fifo_op_q  [DEPTH];
    logic [31:0]      fifo_rs1_q [DEPTH];
    logic [31:0]      fifo_rs2_q [DEPTH];
    logic [TAG_W-1:0] fifo_tag_q [DEPTH];

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    div_state_t       state_q, state_d;
    logic [4:0]       op_q;
    logic [31:0]      rs1_q;
    logic [31:0]      rs2_q;
    logic [TAG_W-1:0] tag_q;
    logic             cdb_valid_q, cdb_valid_d;
    logic [TAG_W-1:0] cdb_tag_q, cdb_tag_d;
    logic [31:0]      cdb_data_q, cdb_data_d;

    logic             full;
    logic             push;
    logic             pop;
    logic             div_start;
    logic             div_done;
    logic [31:0]      div_result;
    logic [4:0]       head_op;
    logic [TAG_W-1:0] head_tag;

    assign full     = (count_q == CNT_W'(DEPTH));
    assign in_ready = ~full;
    assign push     = in_valid && !full && !flush;
    assign head_op  = fifo_op_q[rd_ptr_q];
    assign head_tag = fifo_tag_q[rd_ptr_q];

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_op_q[wr_ptr_q]  <= in_op;
            fifo_rs1_q[wr_ptr_q] <= in_rs1;
            fifo_rs2_q[wr_ptr_q] <= in_rs2;
            fifo_tag_q[wr_ptr_q] <= in_tag;
        end
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            case ({push, pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_comb begin
        state_d     = state_q;
        pop         = 1'b0;
        cdb_valid_d = cdb_valid_q;
        cdb_tag_d   = cdb_tag_q;
        cdb_data_d  = cdb_data_q;
        unique case (state_q)
            S_IDLE: begin
                if (!flush && (count_q != '0)) begin
                    pop = 1'b1;
                    // Non-divide ops bypass the divider and complete with zero.
                    if (is_div_op(head_op)) begin
                        state_d = S_START;
                    end else begin
                        cdb_valid_d = 1'b1;
                        cdb_tag_d   = head_tag;
                        cdb_data_d  = '0;
                        state_d     = S_OUT;
                    end
                end
            end
            S_START: state_d = flush ? S_DRAIN : S_WAIT;
            S_WAIT: begin
                if (div_done) begin
                    if (flush) begin
                        state_d = S_IDLE;
                    end else begin
                        cdb_valid_d = 1'b1;
                        cdb_tag_d   = tag_q;
                        cdb_data_d  = div_result;
                        state_d     = S_OUT;
                    end
                end else if (flush) begin
                    state_d = S_DRAIN;
                end
            end
            S_OUT: begin
                if (flush || cdb_ready) begin
                    cdb_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            S_DRAIN: if (div_done) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            op_q        <= '0;
            rs1_q       <= '0;
            rs2_q       <= '0;
            tag_q       <= '0;
            cdb_valid_q <= 1'b0;
            cdb_tag_q   <= '0;
            cdb_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            cdb_valid_q <= cdb_valid_d;
            cdb_tag_q   <= cdb_tag_d;
            cdb_data_q  <= cdb_data_d;
            if (pop) begin
                op_q  <= head_op;
                rs1_q <= fifo_rs1_q[rd_ptr_q];
                rs2_q <= fifo_rs2_q[rd_ptr_q];
                tag_q <= head_tag;
            end
        end
    end

    assign div_start = (state_q == S_START);

    iter_div32 u_div (
        .clk    (clk),
        .rst_n  (~rst),
        .start  (div_start),
        .op     (op_q),
        .rs1    (rs1_q),
        .rs2    (rs2_q),
        .done   (div_done),
        .result (div_result)
    );

    assign cdb_valid = cdb_valid_q;
    assign cdb_tag   = cdb_tag_q;
    assign cdb_data  = cdb_data_q;
    assign busy      = (count_q != '0) || (state_q != S_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_div_issue_unit.sv
// ============================================================================
// Module : tb_div_issue_unit
// Directed stimulus against an in-order result model of div_issue_unit.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_div_issue_unit;
    import riscv_pkg::*;

    localparam int TAG_W = 6;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [4:0]       in_op;
    logic [31:0]      in_rs1;
    logic [31:0]      in_rs2;
    logic [TAG_W-1:0] in_tag;
    logic             flush;
    logic             cdb_valid;
    logic             cdb_ready;
    logic [TAG_W-1:0] cdb_tag;
    logic [31:0]      cdb_data;
    logic             busy;

    int checks = 0;
    int errors = 0;

    logic [TAG_W-1:0] exp_tag_q[$];
    logic [31:0]      exp_data_q[$];
    logic [TAG_W-1:0] got_tag[$];
    logic [31:0]      got_data[$];
    logic             hold = 1'b0;
    logic [TAG_W-1:0] hold_tag;
    logic [31:0]      hold_data;

    div_issue_unit #(.DEPTH(2), .TAG_W(TAG_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_op     (in_op),
        .in_rs1    (in_rs1),
        .in_rs2    (in_rs2),
        .in_tag    (in_tag),
        .flush     (flush),
        .cdb_valid (cdb_valid),
        .cdb_ready (cdb_ready),
        .cdb_tag   (cdb_tag),
        .cdb_data  (cdb_data),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // RISC-V M-extension divide semantics straight from the ISA rules.
    function automatic logic [31:0] ref_div(input logic [4:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
        logic signed [31:0] sa;
        logic signed [31:0] sb;
        sa = a;
        sb = b;
        if (op[4:2] != 3'b101) return 32'h0;
        case (op[1:0])
            2'b00: begin
                if (b == 32'h0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
                return sa / sb;
            end
            2'b01: return (b == 32'h0) ? 32'hFFFF_FFFF : a / b;
            2'b10: begin
                if (b == 32'h0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
                return sa % sb;
            end
            default: return (b == 32'h0) ? a : a % b;
        endcase
    endfunction

    // Model: every accepted op owes one result, in order; flush/reset cancel all owed.
    always @(negedge clk) begin
        if (rst) begin
            exp_tag_q.delete();
            exp_data_q.delete();
            hold = 1'b0;
        end else begin
            if (hold) begin
                checks++;
                if (!(cdb_valid && cdb_tag == hold_tag && cdb_data == hold_data)) begin
                    errors++;
                    $display("FAIL cdb_hold: got v=%0b tag %0d data %08h expected v=1 tag %0d data %08h",
                             cdb_valid, cdb_tag, cdb_data, hold_tag, hold_data);
                end
            end
            if (cdb_valid) begin
                checks++;
                if (exp_tag_q.size() == 0) begin
                    errors++;
                    $display("FAIL cdb_spurious: got valid tag %0d data %08h expected no result",
                             cdb_tag, cdb_data);
                end
            end
            if (exp_tag_q.size() != 0) begin
                checks++;
                if (!busy) begin
                    errors++;
                    $display("FAIL busy_pending: got 0 expected 1 (%0d owed)", exp_tag_q.size());
                end
            end
            if (flush) begin
                exp_tag_q.delete();
                exp_data_q.delete();
                hold = 1'b0;
            end else begin
                if (cdb_valid && cdb_ready) begin
                    got_tag.push_back(cdb_tag);
                    got_data.push_back(cdb_data);
                    if (exp_tag_q.size() != 0) begin
                        checks++;
                        if (cdb_tag != exp_tag_q[0] || cdb_data != exp_data_q[0]) begin
                            errors++;
                            $display("FAIL cdb_result: got tag %0d data %08h expected tag %0d data %08h",
                                     cdb_tag, cdb_data, exp_tag_q[0], exp_data_q[0]);
                        end
                        void'(exp_tag_q.pop_front());
                        void'(exp_data_q.pop_front());
                    end
                end
                hold      = cdb_valid && !cdb_ready;
                hold_tag  = cdb_tag;
                hold_data = cdb_data;
                if (in_valid && in_ready) begin
                    exp_tag_q.push_back(in_tag);
                    exp_data_q.push_back(ref_div(in_op, in_rs1, in_rs2));
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [TAG_W-1:0] tag);
        int k = 0;
        in_valid = 1'b1;
        in_op    = op;
        in_rs1   = a;
        in_rs2   = b;
        in_tag   = tag;
        @(negedge clk);
        while (!in_ready && k < 400) begin
            @(negedge clk);
            k++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: got in_ready 0 expected 1 (tag %0d)", tag);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_got(input int n);
        int k = 0;
        while (got_tag.size() < n && k < 400) begin
            tick(1);
            k++;
        end
        checks++;
        if (got_tag.size() < n) begin
            errors++;
            $display("FAIL wait_result: got %0d results expected %0d", got_tag.size(), n);
        end
    endtask

    task automatic chk_res(input string name, input int idx, input logic [TAG_W-1:0] tag,
                           input logic [31:0] data);
        logic [TAG_W-1:0] t;
        logic [31:0]      d;
        t = (idx < got_tag.size()) ? got_tag[idx] : 'x;
        d = (idx < got_data.size()) ? got_data[idx] : 'x;
        chk({name, "_tag"}, 32'(t), 32'(tag));
        chk({name, "_data"}, d, data);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        rst = 1'b1; in_valid = 1'b0; in_op = '0; in_rs1 = '0; in_rs2 = '0;
        in_tag = '0; flush = 1'b0; cdb_ready = 1'b1;
        tick(2);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_cdb_valid", 32'(cdb_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        rst = 1'b0;
        tick(1);
        chk("post_rst_in_ready", 32'(in_ready), 32'd1);

        // Single DIV, exactly one result.
        send(OP_DIV, 32'd10, 32'd3, 6'd5);
        wait_got(1);
        tick(10);
        chk("div10_3_count", 32'(got_tag.size()), 32'd1);
        chk_res("div10_3", 0, 6'd5, 32'h0000_0003);
        chk("idle_busy", 32'(busy), 32'd0);

        // Back-to-back, in order.
        base = got_tag.size();
        send(OP_REM, 32'hFFFF_FFF6, 32'd3, 6'd7);
        send(OP_DIVU, 32'hFFFF_FFF6, 32'd2, 6'd8);
        wait_got(base + 2);
        chk_res("rem_neg", base, 6'd7, 32'hFFFF_FFFF);
        chk_res("divu_big", base + 1, 6'd8, 32'h7FFF_FFFB);

        // Backpressure: one executing plus two queued fills the unit.
        base = got_tag.size();
        cdb_ready = 1'b0;
        send(OP_DIV, 32'd7, 32'd2, 6'd10);
        send(OP_DIVU, 32'd99, 32'd10, 6'd11);
        send(OP_REMU, 32'd99, 32'd10, 6'd12);
        chk("full_in_ready", 32'(in_ready), 32'd0);
        tick(45);
        chk("stall_valid", 32'(cdb_valid), 32'd1);
        chk("stall_tag", 32'(cdb_tag), 32'd10);
        cdb_ready = 1'b1;
        wait_got(base + 3);
        chk_res("bp0", base, 6'd10, 32'h0000_0003);
        chk_res("bp1", base + 1, 6'd11, 32'h0000_0009);
        chk_res("bp2", base + 2, 6'd12, 32'h0000_0009);

        // Corner results and a non-divide op.
        base = got_tag.size();
        send(OP_DIV, 32'd100, 32'd0, 6'd21);
        send(OP_REM, 32'd100, 32'd0, 6'd22);
        send(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 6'd23);
        send(5'b01100, 32'd55, 32'd5, 6'd20);
        send(OP_DIV, 32'hFFFF_FF9C, 32'd0, 6'd24);
        wait_got(base + 5);
        chk_res("div_by0", base, 6'd21, 32'hFFFF_FFFF);
        chk_res("rem_by0", base + 1, 6'd22, 32'h0000_0064);
        chk_res("div_ovf", base + 2, 6'd23, 32'h8000_0000);
        chk_res("non_div", base + 3, 6'd20, 32'h0000_0000);
        chk_res("div_neg_by0", base + 4, 6'd24, 32'hFFFF_FFFF);

        // Flush while a result waits on the CDB with the queue full.
        base = got_tag.size();
        cdb_ready = 1'b0;
        send(OP_DIV, 32'd9, 32'd3, 6'd13);
        send(OP_DIV, 32'd8, 32'd2, 6'd14);
        send(OP_DIV, 32'd6, 32'd3, 6'd15);
        tick(45);
        flush = 1'b1;
        tick(1);
        flush = 1'b0;
        chk("flush_out_valid", 32'(cdb_valid), 32'd0);
        chk("flush_out_ready", 32'(in_ready), 32'd1);
        chk("flush_out_busy", 32'(busy), 32'd0);
        cdb_ready = 1'b1;
        tick(60);
        chk("flush_out_none", 32'(got_tag.size()), 32'(base));

        // Flush mid-divide, next op must wait out the drain.
        base = got_tag.size();
        send(OP_DIV, 32'd1000, 32'd7, 6'd3);
        tick(4);
        flush = 1'b1;
        tick(1);
        flush = 1'b0;
        send(OP_DIV, 32'd20, 32'd4, 6'd9);
        wait_got(base + 1);
        tick(5);
        chk("drain_count", 32'(got_tag.size()), 32'(base + 1));
        chk_res("drain_next", base, 6'd9, 32'h0000_0005);

        // Asynchronous reset during WAIT.
        base = got_tag.size();
        send(OP_DIV, 32'd50, 32'd5, 6'd1);
        tick(6);
        #3;
        rst = 1'b1;
        #1;
        chk("arst_valid", 32'(cdb_valid), 32'd0);
        chk("arst_tag", 32'(cdb_tag), 32'd0);
        chk("arst_data", cdb_data, 32'd0);
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_in_ready", 32'(in_ready), 32'd1);
        tick(2);
        rst = 1'b0;
        tick(1);
        send(OP_DIV, 32'd81, 32'd9, 6'd2);
        wait_got(base + 1);
        tick(5);
        chk("arst_count", 32'(got_tag.size()), 32'(base + 1));
        chk_res("arst_next", base, 6'd2, 32'h0000_0009);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
